flex_counter_multi: RTL and testbench

Parametrised multi-channel successor to the single flexible counter. It provides NUM_CH independent counters of NUM_CNT_BITS each. Each channel has its own clear, enable, synchronous load, rollover value and rollover mode, plus a wrap pulse and a sticky overflow bit. It is used by timing and framing logic that needs several programmable counters sharing one clock/reset domain.

---
 rtl/flex_counter_pkg.sv | 17 +
 rtl/flex_counter_ch.sv | 105 ++++++++++
 rtl/flex_counter_multi.sv | 44 ++++
 tb/tb_flex_counter_multi.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flex_counter_pkg.sv
// Shared types for the multi-channel flexible counter.
// Rollover modes and the wide all-ones source constant.
package flex_counter_pkg;

  typedef enum logic [1:0] {
    CNT_WRAP1 = 2'b00,
    CNT_WRAP0 = 2'b01,
    CNT_SAT   = 2'b10,
    CNT_FREE  = 2'b11
  } cnt_mode_t;

  localparam int MAX_CNT_BITS = 32;

  // Channels slice their own all-ones value out of this.
  localparam logic [MAX_CNT_BITS-1:0] ALL_ONES_MAX = '1;

endpackage

// File: rtl/flex_counter_ch.sv
// One counter channel: count, rollover flag,
// wrap pulse and sticky overflow registers.
module flex_counter_ch
  import flex_counter_pkg::*;
#(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic                    load,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  input  cnt_mode_t               mode,
  input  logic                    ovf_clr,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag,
  output logic                    wrap_pulse,
  output logic                    ovf_sticky
);

  localparam logic [NUM_CNT_BITS-1:0] ALL_ONES =
    ALL_ONES_MAX[NUM_CNT_BITS-1:0];
  localparam logic [NUM_CNT_BITS-1:0] ONE =
    {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

  logic [NUM_CNT_BITS-1:0] r_cnt;
  logic                    r_flag;
  logic                    r_pulse;
  logic                    r_sticky;

  logic [NUM_CNT_BITS-1:0] w_next;
  logic [NUM_CNT_BITS-1:0] w_inc;
  logic                    w_at_rv;
  logic                    w_at_max;
  logic                    w_wrap;
  logic                    w_lost;
  logic                    w_sticky;

  assign w_inc    = r_cnt + ONE;
  assign w_at_rv  = (r_cnt == rollover_val);
  assign w_at_max = (r_cnt == ALL_ONES);

  // Clear and load override counting and never wrap.
  always_comb begin
    w_next = r_cnt;
    w_wrap = 1'b0;
    w_lost = 1'b0;
    if (clear) begin
      w_next = '0;
    end else if (load) begin
      w_next = load_val;
    end else if (count_enable) begin
      unique case (mode)
        CNT_WRAP1: begin
          w_next = w_at_rv ? ONE : w_inc;
          w_wrap = w_at_rv | w_at_max;
        end
        CNT_WRAP0: begin
          w_next = w_at_rv ? '0 : w_inc;
          w_wrap = w_at_rv | w_at_max;
        end
        CNT_SAT: begin
          w_next = w_at_rv ? r_cnt : w_inc;
          w_lost = w_at_rv;
          w_wrap = ~w_at_rv & w_at_max;
        end
        default: begin
          w_next = w_inc;
          w_wrap = w_at_max;
        end
      endcase
    end
  end

  always_comb begin
    w_sticky = r_sticky;
    if (w_wrap | w_lost) begin
      w_sticky = 1'b1;
    end else if (ovf_clr) begin
      w_sticky = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt    <= '0;
      r_flag   <= 1'b0;
      r_pulse  <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_cnt    <= w_next;
      r_flag   <= (w_next == rollover_val);
      r_pulse  <= w_wrap;
      r_sticky <= w_sticky;
    end
  end

  assign count_out     = r_cnt;
  assign rollover_flag = r_flag;
  assign wrap_pulse    = r_pulse;
  assign ovf_sticky    = r_sticky;

endmodule

// File: rtl/flex_counter_multi.sv
// NUM_CH independent flexible counters sharing
// one clock and asynchronous reset.
module flex_counter_multi
  import flex_counter_pkg::*;
#(
  parameter int NUM_CNT_BITS = 4,
  parameter int NUM_CH       = 2
) (
  input  logic                                 clk,
  input  logic                                 n_rst,
  input  logic [NUM_CH-1:0]                    clear,
  input  logic [NUM_CH-1:0]                    count_enable,
  input  logic [NUM_CH-1:0]                    load,
  input  logic [NUM_CH-1:0][NUM_CNT_BITS-1:0]  load_val,
  input  logic [NUM_CH-1:0][NUM_CNT_BITS-1:0]  rollover_val,
  input  cnt_mode_t [NUM_CH-1:0]               mode,
  input  logic [NUM_CH-1:0]                    ovf_clr,
  output logic [NUM_CH-1:0][NUM_CNT_BITS-1:0]  count_out,
  output logic [NUM_CH-1:0]                    rollover_flag,
  output logic [NUM_CH-1:0]                    wrap_pulse,
  output logic [NUM_CH-1:0]                    ovf_sticky
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    flex_counter_ch #(
      .NUM_CNT_BITS(NUM_CNT_BITS)
    ) u_ch (
      .clk          (clk),
      .n_rst        (n_rst),
      .clear        (clear[g]),
      .count_enable (count_enable[g]),
      .load         (load[g]),
      .load_val     (load_val[g]),
      .rollover_val (rollover_val[g]),
      .mode         (mode[g]),
      .ovf_clr      (ovf_clr[g]),
      .count_out    (count_out[g]),
      .rollover_flag(rollover_flag[g]),
      .wrap_pulse   (wrap_pulse[g]),
      .ovf_sticky   (ovf_sticky[g])
    );
  end

endmodule

// File: tb/tb_flex_counter_multi.sv
// Bench for flex_counter_multi: directed scenarios
// plus random traffic against an arithmetic model.
module tb_flex_counter_multi;
  import flex_counter_pkg::*;

  localparam int W   = 4;
  localparam int NCH = 3;
  localparam int M   = 1 << W;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic [NCH-1:0] clear, en, load, ovf_clr;
  logic [NCH-1:0][W-1:0] load_val, rv;
  cnt_mode_t [NCH-1:0] mode;
  logic [NCH-1:0][W-1:0] count_out;
  logic [NCH-1:0] rollover_flag, wrap_pulse, ovf_sticky;

  int checks = 0;
  int errors = 0;

  int m_cnt[NCH];
  bit m_flag[NCH], m_pulse[NCH], m_sticky[NCH];

  flex_counter_multi #(
    .NUM_CNT_BITS(W),
    .NUM_CH(NCH)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .count_enable (en),
    .load         (load),
    .load_val     (load_val),
    .rollover_val (rv),
    .mode         (mode),
    .ovf_clr      (ovf_clr),
    .count_out    (count_out),
    .rollover_flag(rollover_flag),
    .wrap_pulse   (wrap_pulse),
    .ovf_sticky   (ovf_sticky)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_cnt[c] = 0;
      m_flag[c] = 0;
      m_pulse[c] = 0;
      m_sticky[c] = 0;
    end
  endtask

  // One clock: model the edge from the current inputs,
  // then land 1 time unit past the edge.
  task automatic tick();
    int n[NCH];
    bit w[NCH], s[NCH];
    for (int c = 0; c < NCH; c++) begin
      int cur;
      int r;
      bit lost;
      cur = m_cnt[c];
      r = int'(rv[c]);
      n[c] = cur;
      w[c] = 0;
      lost = 0;
      if (clear[c]) n[c] = 0;
      else if (load[c]) n[c] = int'(load_val[c]);
      else if (en[c]) begin
        if (cur == r && mode[c] == CNT_WRAP1) begin
          n[c] = 1; w[c] = 1;
        end else if (cur == r && mode[c] == CNT_WRAP0) begin
          n[c] = 0; w[c] = 1;
        end else if (cur == r && mode[c] == CNT_SAT) begin
          lost = 1;
        end else begin
          n[c] = (cur + 1) % M;
          w[c] = (n[c] == 0);
        end
      end
      s[c] = (w[c] || lost) ? 1'b1 :
             (ovf_clr[c] ? 1'b0 : m_sticky[c]);
      m_flag[c] = (n[c] == r);
    end
    @(posedge clk);
    for (int c = 0; c < NCH; c++) begin
      m_cnt[c] = n[c];
      m_pulse[c] = w[c];
      m_sticky[c] = s[c];
    end
    #1;
  endtask

  task automatic idle();
    clear = '0; en = '0; load = '0; ovf_clr = '0;
  endtask

  task automatic prep();
    idle();
    clear = '1;
    ovf_clr = '1;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    load_val = '0;
    rv = '0;
    for (int c = 0; c < NCH; c++) mode[c] = CNT_WRAP1;
    n_rst = 1'b0;
    model_reset();
    #13;
    for (int c = 0; c < NCH; c++) begin
      checks++;
      if (count_out[c] !== '0 || rollover_flag[c] !== 1'b0 ||
          wrap_pulse[c] !== 1'b0 || ovf_sticky[c] !== 1'b0) begin
        errors++;
        $display("FAIL reset ch%0d got cnt=%0d f=%b p=%b s=%b exp all 0",
                 c, count_out[c], rollover_flag[c],
                 wrap_pulse[c], ovf_sticky[c]);
      end
    end
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (count_out !== '0 || ovf_sticky !== '0) begin
      errors++;
      $display("FAIL reset_release got cnt=%h s=%b exp 0",
               count_out, ovf_sticky);
    end
  endtask

  task automatic test_wrap1();
    int exp_c[8] = '{1, 2, 3, 4, 5, 1, 2, 3};
    prep();
    mode[0] = CNT_WRAP1;
    rv[0] = 4'd5;
    en[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (count_out[0] !== W'(exp_c[i]) ||
          rollover_flag[0] !== (exp_c[i] == 5) ||
          wrap_pulse[0] !== (i == 5)) begin
        errors++;
        $display("FAIL wrap1[%0d] got c=%0d f=%b p=%b exp c=%0d f=%b p=%b",
                 i, count_out[0], rollover_flag[0], wrap_pulse[0],
                 exp_c[i], exp_c[i] == 5, i == 5);
      end
    end
    idle();
    checks++;
    if (ovf_sticky[0] !== 1'b1) begin
      errors++;
      $display("FAIL wrap1_sticky got %b exp 1", ovf_sticky[0]);
    end
  endtask

  task automatic test_wrap0();
    int exp_c[5] = '{1, 2, 3, 0, 1};
    prep();
    mode[1] = CNT_WRAP0;
    rv[1] = 4'd3;
    en[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (count_out[1] !== W'(exp_c[i]) || wrap_pulse[1] !== (i == 3)) begin
        errors++;
        $display("FAIL wrap0[%0d] got c=%0d p=%b exp c=%0d p=%b",
                 i, count_out[1], wrap_pulse[1], exp_c[i], i == 3);
      end
    end
    idle();
    ovf_clr[1] = 1'b1;
    tick();
    checks++;
    if (ovf_sticky[1] !== 1'b0) begin
      errors++;
      $display("FAIL wrap0_ovf_clr got %b exp 0", ovf_sticky[1]);
    end
    idle();
    en[1] = 1'b1;
    tick();
    tick();
    ovf_clr[1] = 1'b1;
    tick();
    checks++;
    if (count_out[1] !== '0 || wrap_pulse[1] !== 1'b1 ||
        ovf_sticky[1] !== 1'b1) begin
      errors++;
      $display("FAIL wrap0_set_wins got c=%0d p=%b s=%b exp 0 1 1",
               count_out[1], wrap_pulse[1], ovf_sticky[1]);
    end
    idle();
  endtask

  task automatic test_sat();
    prep();
    mode[2] = CNT_SAT;
    rv[2] = 4'd9;
    load_val[2] = 4'd8;
    load[2] = 1'b1;
    tick();
    idle();
    checks++;
    if (count_out[2] !== 4'd8 || rollover_flag[2] !== 1'b0) begin
      errors++;
      $display("FAIL sat_load got c=%0d f=%b exp 8 0",
               count_out[2], rollover_flag[2]);
    end
    en[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (count_out[2] !== 4'd9 || rollover_flag[2] !== 1'b1 ||
          wrap_pulse[2] !== 1'b0 || ovf_sticky[2] !== (i >= 1)) begin
        errors++;
        $display("FAIL sat[%0d] got c=%0d f=%b p=%b s=%b exp 9 1 0 %b",
                 i, count_out[2], rollover_flag[2], wrap_pulse[2],
                 ovf_sticky[2], i >= 1);
      end
    end
    idle();
  endtask

  task automatic test_priority();
    int exp_c[3] = '{15, 0, 1};
    prep();
    mode[0] = CNT_WRAP1;
    mode[1] = CNT_WRAP1;
    rv[0] = 4'd4;
    rv[1] = 4'd4;
    load_val[0] = 4'd7;
    load_val[1] = 4'd7;
    clear[0] = 1'b1;
    load[1:0] = 2'b11;
    en[1:0] = 2'b11;
    tick();
    idle();
    checks++;
    if (count_out[0] !== 4'd0 || count_out[1] !== 4'd7) begin
      errors++;
      $display("FAIL priority got ch0=%0d ch1=%0d exp 0 7",
               count_out[0], count_out[1]);
    end
    load_val[0] = 4'd14;
    load[0] = 1'b1;
    tick();
    idle();
    en[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (count_out[0] !== W'(exp_c[i]) || wrap_pulse[0] !== (i == 1) ||
          wrap_pulse[0] !== m_pulse[0]) begin
        errors++;
        $display("FAIL above_rv[%0d] got c=%0d p=%b exp c=%0d p=%b",
                 i, count_out[0], wrap_pulse[0], exp_c[i], i == 1);
      end
    end
    idle();
  endtask

  task automatic test_multi();
    int wraps = 0;
    prep();
    mode[0] = CNT_FREE;
    rv[0] = 4'd15;
    mode[1] = CNT_WRAP1;
    rv[1] = 4'd2;
    mode[2] = CNT_WRAP1;
    rv[2] = 4'd5;
    en = 3'b011;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (wrap_pulse[0]) wraps++;
      checks++;
      if (count_out[0] !== W'((i + 1) % M) ||
          count_out[1] !== W'(i % 2 + 1) ||
          count_out[2] !== '0 || rollover_flag[2] !== 1'b0 ||
          wrap_pulse[2] !== 1'b0 || ovf_sticky[2] !== 1'b0) begin
        errors++;
        $display("FAIL multi[%0d] got %0d %0d %0d f2=%b p2=%b s2=%b exp %0d %0d 0 0 0 0",
                 i, count_out[0], count_out[1], count_out[2],
                 rollover_flag[2], wrap_pulse[2], ovf_sticky[2],
                 (i + 1) % M, i % 2 + 1);
      end
    end
    idle();
    checks++;
    if (wraps != 1) begin
      errors++;
      $display("FAIL multi_wraps got %0d exp 1", wraps);
    end
  endtask

  task automatic test_async_reset();
    prep();
    mode[0] = CNT_WRAP1;
    rv[0] = 4'd10;
    en[0] = 1'b1;
    repeat (6) tick();
    checks++;
    if (count_out[0] !== 4'd6) begin
      errors++;
      $display("FAIL pre_reset got %0d exp 6", count_out[0]);
    end
    #2;
    n_rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (count_out !== '0 || rollover_flag !== '0 ||
        wrap_pulse !== '0 || ovf_sticky !== '0) begin
      errors++;
      $display("FAIL async_reset got cnt=%h f=%b p=%b s=%b exp 0",
               count_out, rollover_flag, wrap_pulse, ovf_sticky);
    end
    @(negedge clk);
    n_rst = 1'b1;
    tick();
    checks++;
    if (count_out[0] !== 4'd1) begin
      errors++;
      $display("FAIL after_reset got %0d exp 1", count_out[0]);
    end
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NCH; c++) begin
        clear[c] = ($urandom_range(15) == 0);
        load[c] = ($urandom_range(7) == 0);
        en[c] = ($urandom_range(3) != 0);
        ovf_clr[c] = ($urandom_range(7) == 0);
        load_val[c] = W'($urandom);
        if ($urandom_range(15) == 0) rv[c] = W'($urandom);
        if ($urandom_range(31) == 0) mode[c] = cnt_mode_t'($urandom_range(3));
      end
      tick();
      for (int c = 0; c < NCH; c++) begin
        checks++;
        if (count_out[c] !== W'(m_cnt[c]) ||
            rollover_flag[c] !== m_flag[c] ||
            wrap_pulse[c] !== m_pulse[c] ||
            ovf_sticky[c] !== m_sticky[c]) begin
          errors++;
          $display("FAIL rand[%0d] ch%0d got c=%0d f=%b p=%b s=%b exp c=%0d f=%b p=%b s=%b",
                   i, c, count_out[c], rollover_flag[c], wrap_pulse[c],
                   ovf_sticky[c], m_cnt[c], m_flag[c], m_pulse[c],
                   m_sticky[c]);
        end
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_wrap1();
    test_wrap0();
    test_sat();
    test_priority();
    test_multi();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
